// File: rtl/stm_block_sequencer.sv
// STM read-side sequencer: walks a 16-bit register list and emits one memory
// write beat per listed register, lowest register index at the lowest address.
//
// state | meaning
// IDLE  | waiting for start; request inputs captured on start
// FETCH | read lowest pending register, or go to FIN when none remain
// XFER  | beat presented on mem_*, held until mem_ready
// FIN   | one-cycle done pulse plus optional base writeback
module stm_block_sequencer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  reg_list,
    input  logic [W-1:0] base,
    input  logic [1:0]   mode,
    input  logic         wb_en,
    input  logic [3:0]   rn,
    output logic [3:0]   rf_addr,
    input  logic [W-1:0] rf_data,
    input  logic [W-1:0] r15_val,
    output logic         mem_valid,
    input  logic         mem_ready,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_data,
    output logic         wb_we,
    output logic [3:0]   wb_addr,
    output logic [W-1:0] wb_data,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, FETCH, XFER, FIN} state_t;

    localparam logic [W-1:0] WORD = {{(W-3){1'b0}}, 3'd4};

    state_t       state_q, state_d;
    logic [15:0]  mask_q;
    logic [W-1:0] addr_q, data_q, fbase_q;
    logic         wb_en_q;
    logic [3:0]   rn_q;
    logic [4:0]   n_cnt;
    logic [3:0]   low_idx;
    logic [W-1:0] ofs, a0, fbase;

    always_comb begin
        n_cnt = '0;
        for (int i = 0; i < 16; i++) n_cnt = n_cnt + 5'(reg_list[i]);
        low_idx = '0;
        for (int i = 15; i >= 0; i--) if (mask_q[i]) low_idx = 4'(i);
    end

    // mode = {P,U}; the lowest address is always where the lowest register lands
    always_comb begin
        ofs   = {{(W-7){1'b0}}, n_cnt, 2'b00};
        fbase = mode[0] ? (base + ofs) : (base - ofs);
        case (mode)
            2'b00:   a0 = base - ofs + WORD;
            2'b01:   a0 = base;
            2'b10:   a0 = base - ofs;
            default: a0 = base + WORD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        rf_addr   = '0;
        mem_valid = 1'b0;
        done      = 1'b0;
        wb_we     = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = FETCH;
            FETCH: begin
                rf_addr = low_idx;
                state_d = (mask_q == 16'h0000) ? FIN : XFER;
            end
            XFER: begin
                mem_valid = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            FIN: begin
                done    = 1'b1;
                wb_we   = wb_en_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign wb_addr  = wb_we ? rn_q : '0;
    assign wb_data  = wb_we ? fbase_q : '0;

    // wb_en is only honoured for a non-empty list
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            fbase_q <= '0;
            wb_en_q <= 1'b0;
            rn_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    mask_q  <= reg_list;
                    addr_q  <= a0;
                    fbase_q <= fbase;
                    wb_en_q <= wb_en && (reg_list != 16'h0000);
                    rn_q    <= rn;
                end
                FETCH: if (mask_q != 16'h0000) begin
                    data_q <= (low_idx == 4'd15) ? r15_val : rf_data;
                    mask_q <= mask_q & ~(16'h0001 << low_idx);
                end
                XFER: if (mem_ready) addr_q <= addr_q + WORD;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stm_block_sequencer.sv
// Scoreboard bench for stm_block_sequencer: a list-level model predicts beats
// and completion; a negedge monitor pops and compares whatever the DUT presents.
module tb_stm_block_sequencer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          rel;
    } beat_t;

    typedef struct {
        logic        we;
        logic [3:0]  a;
        logic [31:0] d;
        int          rel;
    } done_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] reg_list;
    logic [31:0] base;
    logic [1:0]  mode;
    logic        wb_en;
    logic [3:0]  rn;
    logic [3:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] r15_val;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic        done;

    logic [31:0] rf [16];
    assign rf_data = rf[rf_addr];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int stall_left = 0;
    bit rdy_rand = 1'b0;

    beat_t exp_beats[$];
    done_t exp_done[$];

    stm_block_sequencer #(.W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .reg_list(reg_list),
        .base(base), .mode(mode), .wb_en(wb_en), .rn(rn),
        .rf_addr(rf_addr), .rf_data(rf_data), .r15_val(r15_val),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: beat k goes to the k-th lowest listed register; addresses follow
    // the ARM block rules (increment-after/before, decrement-after/before).
    task automatic model(input logic [15:0] l, input logic [31:0] b, input logic [1:0] m,
                         input logic we, input logic [3:0] r, input bit timed);
        int n;
        int k;
        beat_t bt;
        done_t dn;
        n = $countones(l);
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (l[i]) begin
                if (m[0]) bt.addr = b + 32'(4 * (k + int'(m[1])));
                else      bt.addr = b - 32'(4 * (n - k - (m[1] ? 0 : 1)));
                bt.data = (i == 15) ? r15_val : rf[i];
                bt.rel  = timed ? 2 + 2 * k : -1;
                exp_beats.push_back(bt);
                k++;
            end
        end
        dn.we  = we && (n != 0);
        dn.a   = r;
        dn.d   = m[0] ? b + 32'(4 * n) : b - 32'(4 * n);
        dn.rel = timed ? 2 * n + 2 : -1;
        exp_done.push_back(dn);
    endtask

    task automatic drive_start(input logic [15:0] l, input logic [31:0] b, input logic [1:0] m,
                               input logic we, input logic [3:0] r, input bit poke);
        @(posedge clk); #1;
        start = 1'b1; reg_list = l; base = b; mode = m; wb_en = we; rn = r;
        @(posedge clk); #1;
        start = 1'b0;
        reg_list = 16'($urandom); base = $urandom; mode = 2'($urandom);
        wb_en = 1'($urandom); rn = 4'($urandom);
        if (poke) begin
            start = 1'b1; reg_list = 16'hFFFF; wb_en = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic run_op(input logic [15:0] l, input logic [31:0] b, input logic [1:0] m,
                          input logic we, input logic [3:0] r, input bit timed, input bit poke);
        int d0;
        int t;
        for (int i = 0; i < 15; i++) rf[i] = $urandom;
        model(l, b, m, we, r, timed);
        d0 = done_cnt;
        drive_start(l, b, m, we, r, poke);
        t = 0;
        while (done_cnt == d0 && t < 400) begin
            @(negedge clk); #1;
            t++;
        end
        if (done_cnt == d0) begin
            checks++; failures++;
            $display("FAIL op_timeout list=%h actual=no_done expected=done", l);
            exp_beats.delete();
            exp_done.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0 && mem_valid) begin
                mem_ready = 1'b0;
                stall_left--;
            end else if (rdy_rand) mem_ready = ($urandom_range(0, 2) != 0);
            else mem_ready = 1'b1;
        end
    end

    initial begin : monitor
        bit stalled;
        logic [31:0] hold_addr, hold_data;
        beat_t bt;
        done_t dn;
        stalled = 1'b0;
        hold_addr = '0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (start && !busy) start_cyc = cyc;
                if (mem_valid && stalled) begin
                    chk("hold_addr", mem_addr, hold_addr);
                    chk("hold_data", mem_data, hold_data);
                end
                stalled   = mem_valid && !mem_ready;
                hold_addr = mem_addr;
                hold_data = mem_data;
                if (mem_valid && mem_ready) begin
                    acc_cnt++;
                    if (exp_beats.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_beat actual=%h/%h expected=none", mem_addr, mem_data);
                    end else begin
                        bt = exp_beats.pop_front();
                        chk("beat_addr", mem_addr, bt.addr);
                        chk("beat_data", mem_data, bt.data);
                        if (bt.rel >= 0) chk("beat_cycle", 32'(cyc - start_cyc), 32'(bt.rel));
                    end
                end
                if (wb_we && !done) begin
                    checks++; failures++;
                    $display("FAIL wb_without_done actual=1 expected=0");
                end
                if (done) begin
                    done_cnt++;
                    if (exp_done.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_done actual=1 expected=0");
                    end else begin
                        dn = exp_done.pop_front();
                        chk("beats_left", 32'(exp_beats.size()), 32'd0);
                        chk("wb_we", 32'(wb_we), 32'(dn.we));
                        if (dn.we) begin
                            chk("wb_addr", 32'(wb_addr), 32'(dn.a));
                            chk("wb_data", wb_data, dn.d);
                        end
                        if (dn.rel >= 0) chk("done_cycle", 32'(cyc - start_cyc), 32'(dn.rel));
                    end
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_data"}, mem_data, 32'd0);
        chk({tag, "_wb_we"}, 32'(wb_we), 32'd0);
        chk({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_rf_addr"}, 32'(rf_addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int t;
        int a0;
        logic [15:0] l;
        reset = 1'b0; start = 1'b0; reg_list = '0; base = '0; mode = '0;
        wb_en = 1'b0; rn = '0; r15_val = 32'h0000_0058;
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        run_op(16'h00A2, 32'h0000_1000, 2'b01, 1'b1, 4'd3, 1'b1, 1'b0);
        r15_val = 32'h0000_0058;
        run_op(16'h8001, 32'h0000_2000, 2'b10, 1'b1, 4'd13, 1'b1, 1'b0);
        stall_left = 3;
        run_op(16'h0003, 32'h0000_3000, 2'b01, 1'b0, 4'd2, 1'b0, 1'b0);
        run_op(16'h0000, 32'h0000_4000, 2'b11, 1'b1, 4'd4, 1'b1, 1'b0);
        run_op(16'h0003, 32'hFFFF_FFFC, 2'b01, 1'b1, 4'd6, 1'b1, 1'b0);
        run_op(16'h0030, 32'h0000_5000, 2'b00, 1'b1, 4'd4, 1'b1, 1'b1);
        run_op(16'h0011, 32'h0000_6000, 2'b11, 1'b1, 4'd4, 1'b1, 1'b0);

        // Abort after the first accepted beat: no later beats, no writeback.
        for (int i = 0; i < 15; i++) rf[i] = $urandom;
        model(16'h000F, 32'h0000_7000, 2'b01, 1'b1, 4'd1, 1'b1);
        exp_beats = exp_beats[0:0];
        exp_done.delete();
        a0 = acc_cnt;
        drive_start(16'h000F, 32'h0000_7000, 2'b01, 1'b1, 4'd1, 1'b0);
        t = 0;
        while (acc_cnt == a0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("abort_first_beat", 32'(acc_cnt - a0), 32'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_beats_left", 32'(exp_beats.size()), 32'd0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       l = 16'h0000;
                1:       l = 16'hFFFF;
                default: l = 16'($urandom);
            endcase
            rdy_rand = (n % 2 == 1);
            r15_val = $urandom;
            run_op(l, $urandom & 32'hFFFF_FFFC, 2'($urandom), 1'($urandom), 4'($urandom),
                   !rdy_rand, (n % 5 == 0));
        end
        rdy_rand = 1'b0;
        chk("final_beats_left", 32'(exp_beats.size()), 32'd0);
        chk("final_done_left", 32'(exp_done.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
